// File: rtl/ex_mem_pkg.sv
// rtl/ex_mem_pkg.sv - shared pipeline defines and EX/MEM update-mode helpers
package ex_mem_pkg;

    localparam logic RstEnable    = 1'b1;
    localparam logic RstDisable   = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam int RegBus       = 32;
    localparam int RegAddrBus   = 5;
    localparam int DoubleRegBus = 64;
    localparam int StallBus     = 6;

    localparam logic [RegBus-1:0]       ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0]   ZeroAddr   = '0;
    localparam logic [DoubleRegBus-1:0] ZeroDouble = '0;

    // Bit positions within the pipeline stall vector
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef enum logic [1:0] {
        UPD_ADVANCE,
        UPD_HOLD,
        UPD_BUBBLE,
        UPD_FLUSH
    } upd_mode_t;

    // EX running with MEM stalled cannot happen legally; it falls through to advance.
    function automatic upd_mode_t pick_mode(input logic flush,
                                            input logic ex_stall,
                                            input logic mem_stall);
        if (flush)
            return UPD_FLUSH;
        else if (ex_stall && !mem_stall)
            return UPD_BUBBLE;
        else if (ex_stall && mem_stall)
            return UPD_HOLD;
        else
            return UPD_ADVANCE;
    endfunction

    // The madd/msub step counter only ever carries 0, 1 or 2.
    function automatic logic [1:0] clamp_cnt(input logic [1:0] cnt);
        return (cnt == 2'd3) ? 2'd0 : cnt;
    endfunction

endpackage

// File: rtl/ex_mem.sv
// rtl/ex_mem.sv - EX/MEM pipeline register with flush, bubble and hold handling
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int EX_IDX  = STALL_EX,
    parameter int MEM_IDX = STALL_MEM
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic                    flush,
    input  logic [RegAddrBus-1:0]   ex_wd,
    input  logic                    ex_wreg,
    input  logic [RegBus-1:0]       ex_wdata,
    input  logic [RegBus-1:0]       ex_hi,
    input  logic [RegBus-1:0]       ex_lo,
    input  logic                    ex_whilo,
    input  logic [DoubleRegBus-1:0] hilo_i,
    input  logic [1:0]              cnt_i,
    output logic [RegAddrBus-1:0]   mem_wd,
    output logic                    mem_wreg,
    output logic [RegBus-1:0]       mem_wdata,
    output logic [RegBus-1:0]       mem_hi,
    output logic [RegBus-1:0]       mem_lo,
    output logic                    mem_whilo,
    output logic [DoubleRegBus-1:0] hilo_o,
    output logic [1:0]              cnt_o
);

    upd_mode_t mode;

    // Only the EX and MEM bits matter here; the rest of the vector is ignored.
    logic stall_unused;
    assign stall_unused = ^stall;

    always_comb begin
        mode = UPD_ADVANCE;
        mode = pick_mode(flush, stall[EX_IDX], stall[MEM_IDX]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            mem_wd    <= ZeroAddr;
            mem_wreg  <= WriteDisable;
            mem_wdata <= ZeroWord;
            mem_hi    <= ZeroWord;
            mem_lo    <= ZeroWord;
            mem_whilo <= WriteDisable;
            hilo_o    <= ZeroDouble;
            cnt_o     <= 2'd0;
        end else begin
            case (mode)
                UPD_FLUSH: begin
                    // Any in-flight madd/msub partial product is dropped too.
                    mem_wd    <= ZeroAddr;
                    mem_wreg  <= WriteDisable;
                    mem_wdata <= ZeroWord;
                    mem_hi    <= ZeroWord;
                    mem_lo    <= ZeroWord;
                    mem_whilo <= WriteDisable;
                    hilo_o    <= ZeroDouble;
                    cnt_o     <= 2'd0;
                end
                UPD_BUBBLE: begin
                    // EX is mid madd/msub: send a bubble to MEM, keep the accumulator cycling.
                    mem_wd    <= ZeroAddr;
                    mem_wreg  <= WriteDisable;
                    mem_wdata <= ZeroWord;
                    mem_hi    <= ZeroWord;
                    mem_lo    <= ZeroWord;
                    mem_whilo <= WriteDisable;
                    hilo_o    <= hilo_i;
                    cnt_o     <= clamp_cnt(cnt_i);
                end
                UPD_HOLD: begin
                    mem_wd    <= mem_wd;
                    mem_wreg  <= mem_wreg;
                    mem_wdata <= mem_wdata;
                    mem_hi    <= mem_hi;
                    mem_lo    <= mem_lo;
                    mem_whilo <= mem_whilo;
                    hilo_o    <= hilo_o;
                    cnt_o     <= cnt_o;
                end
                default: begin
                    mem_wd    <= ex_wd;
                    mem_wreg  <= ex_wreg;
                    mem_wdata <= ex_wdata;
                    mem_hi    <= ex_hi;
                    mem_lo    <= ex_lo;
                    mem_whilo <= ex_whilo;
                    hilo_o    <= ZeroDouble;
                    cnt_o     <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem.sv
// tb/tb_ex_mem.sv - self-checking bench for the EX/MEM pipeline register
module tb_ex_mem;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } outs_t;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int checks = 0;
    int passes = 0;
    outs_t exp_s;
    outs_t act;

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    assign act = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // EX running while MEM is stalled must never be presented
    always @(posedge clk) begin
        if (!rst)
            assert (!(stall[3] == 1'b0 && stall[4] == 1'b1))
                else $error("illegal stall pattern %b", stall);
    end

    // Reference: what the MEM-side outputs should be after the next edge
    function automatic outs_t model_next(input outs_t cur);
        outs_t n;
        n = '0;
        if (flush) begin
            n = '0;
        end else if (stall[3] && stall[4]) begin
            n = cur;
        end else if (stall[3]) begin
            n.hilo = hilo_i;
            n.cnt  = (cnt_i == 2'd3) ? 2'd0 : cnt_i;
        end else begin
            n.wd    = ex_wd;
            n.wreg  = ex_wreg;
            n.wdata = ex_wdata;
            n.hi    = ex_hi;
            n.lo    = ex_lo;
            n.whilo = ex_whilo;
        end
        return n;
    endfunction

    task automatic tick();
        exp_s = model_next(exp_s);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = '0; flush = 0; ex_wd = '0; ex_wreg = 0; ex_wdata = '0;
        ex_hi = '0; ex_lo = '0; ex_whilo = 0; hilo_i = '0; cnt_i = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        exp_s = '0;
        #2;
        checks++;
        if (act !== 128'(0) && act !== '0) $display("FAIL reset_initial actual=%h required=0", act);
        else passes++;
        @(negedge clk);
        rst = 0;
        // load nonzero then hit reset mid-cycle
        ex_wd = 5'd17; ex_wreg = 1; ex_wdata = 32'hDEAD_BEEF; ex_whilo = 1;
        ex_hi = 32'h1; ex_lo = 32'h2;
        tick();
        checks++;
        if (act !== exp_s) $display("FAIL reset_preload actual=%h required=%h", act, exp_s);
        else passes++;
        #2 rst = 1;
        #1;
        exp_s = '0;
        checks++;
        if (act !== exp_s) $display("FAIL reset_async actual=%h required=%h", act, exp_s);
        else passes++;
        #1 rst = 0;
        clear_inputs();
    endtask

    task automatic test_advance();
        clear_inputs();
        ex_wd = 5'd3; ex_wreg = 1; ex_wdata = 32'h1234_5678;
        tick();
        checks++;
        if (mem_wd !== 5'd3 || mem_wreg !== 1'b1 || mem_wdata !== 32'h1234_5678 || cnt_o !== 2'd0)
            $display("FAIL advance wd=%0d wreg=%b wdata=%h cnt=%0d required 3/1/12345678/0",
                     mem_wd, mem_wreg, mem_wdata, cnt_o);
        else passes++;
        checks++;
        if (act !== exp_s) $display("FAIL advance_model actual=%h required=%h", act, exp_s);
        else passes++;
    endtask

    task automatic test_bubble();
        clear_inputs();
        ex_wreg = 1; ex_whilo = 1; ex_wdata = 32'h5;
        stall = 6'b001111; hilo_i = 64'h0000_0001_FFFF_FFFE; cnt_i = 2'd1;
        tick();
        checks++;
        if (mem_wreg !== 1'b0 || mem_whilo !== 1'b0 || hilo_o !== 64'h0000_0001_FFFF_FFFE || cnt_o !== 2'd1)
            $display("FAIL bubble wreg=%b whilo=%b hilo=%h cnt=%0d required 0/0/00000001fffffffe/1",
                     mem_wreg, mem_whilo, hilo_o, cnt_o);
        else passes++;
        checks++;
        if (act !== exp_s) $display("FAIL bubble_model actual=%h required=%h", act, exp_s);
        else passes++;
    endtask

    task automatic test_hold();
        clear_inputs();
        ex_wdata = 32'hAAAA_5555; ex_wreg = 1; ex_wd = 5'd9;
        tick();
        stall = 6'b011111;
        hilo_i = 64'hCAFE_0000_0000_BEEF; cnt_i = 2'd2;
        for (int i = 0; i < 3; i++) begin
            ex_wdata = $urandom;
            tick();
            checks++;
            if (mem_wdata !== 32'hAAAA_5555 || hilo_o !== 64'h0 || cnt_o !== 2'd0)
                $display("FAIL hold_%0d wdata=%h hilo=%h cnt=%0d required aaaa5555/0/0",
                         i, mem_wdata, hilo_o, cnt_o);
            else passes++;
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        stall = 6'b001111; hilo_i = 64'h1234; cnt_i = 2'd1;
        tick();
        flush = 1; hilo_i = 64'h5678; cnt_i = 2'd1;
        ex_wreg = 1; ex_wdata = 32'h77;
        tick();
        checks++;
        if (act !== '0) $display("FAIL flush_over_stall actual=%h required=0", act);
        else passes++;
        flush = 0;
    endtask

    task automatic test_hilo();
        clear_inputs();
        ex_whilo = 1; ex_hi = 32'hFFFF_FFFF; ex_lo = 32'h0000_0002;
        tick();
        checks++;
        if (mem_whilo !== 1'b1 || mem_hi !== 32'hFFFF_FFFF || mem_lo !== 32'h0000_0002)
            $display("FAIL hilo_pass whilo=%b hi=%h lo=%h required 1/ffffffff/00000002",
                     mem_whilo, mem_hi, mem_lo);
        else passes++;
    endtask

    task automatic test_cnt_clamp();
        clear_inputs();
        stall = 6'b001111; hilo_i = 64'hFFFF_FFFF_FFFF_FFFF; cnt_i = 2'd3;
        tick();
        checks++;
        if (cnt_o !== 2'd0 || hilo_o !== 64'hFFFF_FFFF_FFFF_FFFF)
            $display("FAIL cnt_clamp cnt=%0d hilo=%h required 0/ffffffffffffffff", cnt_o, hilo_o);
        else passes++;
        cnt_i = 2'd2;
        tick();
        checks++;
        if (cnt_o !== 2'd2) $display("FAIL cnt_two cnt=%0d required 2", cnt_o);
        else passes++;
    endtask

    task automatic test_random();
        int kind;
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            stall = 6'($urandom) & 6'b100111;
            if (kind == 1) stall[3] = 1;
            if (kind == 2) stall[4:3] = 2'b11;
            flush    = ($urandom_range(0, 7) == 0);
            ex_wd    = 5'($urandom);
            ex_wreg  = 1'($urandom);
            ex_wdata = $urandom;
            ex_hi    = $urandom;
            ex_lo    = $urandom;
            ex_whilo = 1'($urandom);
            hilo_i   = {$urandom, $urandom};
            cnt_i    = 2'($urandom);
            tick();
            checks++;
            if (act !== exp_s) $display("FAIL random_%0d actual=%h required=%h", i, act, exp_s);
            else passes++;
        end
        flush = 0;
    endtask

    initial begin
        test_reset();
        test_advance();
        test_bubble();
        test_hold();
        test_flush();
        test_hilo();
        test_cnt_clamp();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
